decade_timebase: RTL and testbench
==================================

Name: decade_timebase

Overview:
- Parametrised successor to the fixed-divider clock bank of the frequency meter.
- One shared prescaler feeds a cascade of decade counters, so every output is phase-aligned. Outputs are N_DECADES square-wave timebases plus one-cycle tick strobes.
- Adds per-output glitch-free enables and a synchronous realign.
- Adds a gate-window generator: on request it produces exactly one period of a selected timebase, aligned to that timebase's tick, for counting or period measurement.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz.
- BASE_FREQ, 1000000, frequency of decade 0 in Hz. CLK_FREQ must be divisible by BASE_FREQ; R = CLK_FREQ/BASE_FREQ must be >= 2.
- N_DECADES, 7, number of outputs. Decade k runs at BASE_FREQ/10^k; the default gives 1 MHz down to 1 Hz.
- SEL_W, 3, width of gate_sel. Must satisfy 2^SEL_W >= N_DECADES.

Ports:
- CLK_50  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- sync_clr  in  1  synchronous realign: clears prescaler and all decade counters.
- en  in  N_DECADES  per-output enable mask.
- clk_out  out  N_DECADES  square-wave timebases; bit k is at BASE_FREQ/10^k.
- tick  out  N_DECADES  one-cycle strobe per period of decade k.
- gate_sel  in  SEL_W  decade used for the gate window.
- gate_start  in  1  request a gate window; level-sampled, acted on only when idle.
- gate  out  1  measurement window.
- gate_busy  out  1  high from the cycle after start is accepted until done.
- gate_done  out  1  one-cycle pulse at window end.

Behaviour:
- Reset (nRST low): prescaler, decade counters, clk_out, tick, gate, gate_busy and gate_done are all 0. The gate FSM goes to IDLE and the latched select to 0.
- Prescaler counts 0..R-1 and wraps. Decade counters d[0..N_DECADES-2] each count 0..9.
  - d[0] advances on each prescaler wrap.
  - d[j] advances when d[j-1] wraps.
  - All counters are DIV_W/4-bit wide, DIV_W = clog2(R).
- tick (all registered):
  - tick[0] = 1 in the cycle after the prescaler equals R-1.
  - tick[k] = 1 in the cycle after the prescaler equals R-1 and d[0..k-1] all equal 9.
  - First tick[0] occurs R cycles after reset release.
  - Every tick[k] coincides with a tick[0]. Period is R*10^k cycles.
- clk_out (registered):
  - Raw waveform for decade 0: high while prescaler < floor(R/2). For odd R the high phase is the shorter one.
  - Raw waveform for decade k >= 1: high while d[k-1] < 5.
  - Rising edges of clk_out[k] align with tick[k].
- en[k] is sampled only at tick[k].
  - A disabled output stays 0.
  - Enable and disable both take effect at a tick boundary, so no runt pulses.
  - tick[k] is not masked by en.
- sync_clr: next cycle, prescaler and all decade counters = 0, clk_out = 0, tick = 0. Then the sequence restarts as after reset.
- Gate FSM, states IDLE, ARM, OPEN, DONE:
  - IDLE: gate_start=1 latches sel = min(gate_sel, N_DECADES-1) and moves to ARM.
  - ARM: gate_busy=1; waits for tick[sel]. The cycle after it, moves to OPEN with gate=1.
  - OPEN: gate stays 1 until the next tick[sel]. The cycle after that tick, gate=0, gate_done=1, state DONE.
  - DONE: one cycle, gate_busy=0, then IDLE.
  - Window length is exactly R*10^sel cycles.
  - gate_start during ARM, OPEN or DONE is ignored.
  - gate_sel changes after acceptance are ignored.
- sync_clr in ARM or OPEN aborts: the FSM returns to IDLE next cycle, gate=0, gate_busy=0, no gate_done.
- Simultaneous sync_clr and gate_start in IDLE: sync_clr wins and start is ignored.
- Asynchronous reset mid-window: immediate return to reset values.

Decomposition:
- Shared package holds:
  - Gate FSM state encoding (IDLE/ARM/OPEN/DONE).
  - Constant DECADE_MAX = 9.
  - A function computing R and DIV_W from CLK_FREQ/BASE_FREQ.
- Sub-module decade_cnt (0..9 counter with carry-in, carry-out, wrap and sync clear) is instantiated N_DECADES-1 times via generate.

Test Plan (CLK_FREQ=20, BASE_FREQ=5, R=4, N_DECADES=3, en=3'b111 unless stated):
- Release reset -> tick[0] at cycles 4,8,12…; tick[1] every 40 cycles; tick[2] every 400 cycles. clk_out[0] high 2 of 4 cycles. All tick[2] coincide with tick[1] and tick[0].
- en[1] dropped mid-high-phase -> clk_out[1] completes its current period and goes low at the next tick[1]. Re-enable -> first rising edge coincides with a tick[1].
- gate_sel=1, one-cycle gate_start in IDLE -> gate high exactly 40 consecutive cycles starting the cycle after the next tick[1]. gate_done pulses once as gate falls; gate_busy covers ARM..OPEN.
- gate_sel=7 -> clamped to 2, window = 400 cycles. Second gate_start during OPEN -> no effect.
- sync_clr asserted during OPEN -> gate=0 and gate_busy=0 next cycle, no gate_done. The next tick[0] arrives 4 cycles after sync_clr deasserts.
- nRST pulled low during ARM -> all outputs 0 immediately. After release, the tick schedule matches the first scenario.

Source files
------------

// File: rtl/decade_timebase_pkg.sv
// Shared types, constants and divider helpers for the decade timebase.
package decade_timebase_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StOpen,
        StDone
    } gate_state_e;

    localparam int unsigned DECADE_MAX  = 9;
    localparam int unsigned DECADE_HALF = 5;
    localparam int unsigned DECADE_W    = 4;

    // Prescaler ratio R and its counter width; R must be >= 2.
    function automatic int unsigned calc_ratio(input int unsigned clk_freq,
                                               input int unsigned base_freq);
        return clk_freq / base_freq;
    endfunction

    function automatic int unsigned calc_div_w(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/decade_cnt.sv
// Single 0..9 decade stage with carry-in, carry-out on wrap and synchronous clear.
module decade_cnt
    import decade_timebase_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                sync_clr_i,
    input  logic                carry_i,
    output logic [DECADE_W-1:0] count_next_o,
    output logic                carry_o
);

    logic [DECADE_W-1:0] count_q, count_d;
    logic                at_max;

    always_comb begin
        at_max  = (count_q == DECADE_W'(DECADE_MAX));
        count_d = count_q;
        if (sync_clr_i) begin
            count_d = '0;
        end else if (carry_i) begin
            count_d = at_max ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_next_o = count_d;
    assign carry_o      = carry_i & at_max;

endmodule

// File: rtl/decade_timebase.sv
// Phase-aligned decade timebase bank: shared prescaler, cascaded decades,
// glitch-free per-output enables and a one-period gate-window generator.
module decade_timebase
    import decade_timebase_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BASE_FREQ = 1000000,
    parameter int unsigned N_DECADES = 7,
    parameter int unsigned SEL_W     = 3
) (
    input  logic                 CLK_50,
    input  logic                 nRST,
    input  logic                 sync_clr,
    input  logic [N_DECADES-1:0] en,
    output logic [N_DECADES-1:0] clk_out,
    output logic [N_DECADES-1:0] tick,
    input  logic [SEL_W-1:0]     gate_sel,
    input  logic                 gate_start,
    output logic                 gate,
    output logic                 gate_busy,
    output logic                 gate_done
);

    localparam int unsigned      R       = calc_ratio(CLK_FREQ, BASE_FREQ);
    localparam int unsigned      DIV_W   = calc_div_w(R);
    localparam int unsigned      HALF    = R / 2;
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_DECADES - 1);

    logic [DIV_W-1:0]     pre_q, pre_d;
    logic                 pre_wrap;
    logic [N_DECADES-1:0] tick_raw;
    logic [DECADE_W-1:0]  dec_next [N_DECADES-1];
    logic [N_DECADES-1:0] tick_q, tick_d;
    logic [N_DECADES-1:0] en_q, en_d;
    logic [N_DECADES-1:0] raw_d;
    logic [N_DECADES-1:0] clk_out_q, clk_out_d;

    assign pre_wrap    = (pre_q == DIV_W'(R - 1));
    assign pre_d       = (sync_clr || pre_wrap) ? '0 : pre_q + 1'b1;
    assign tick_raw[0] = pre_wrap;

    for (genvar j = 0; j < N_DECADES - 1; j++) begin : g_dec
        logic carry_in;
        logic carry_out;
        if (j == 0) begin : g_first
            assign carry_in = pre_wrap;
        end else begin : g_chain
            assign carry_in = g_dec[j-1].carry_out;
        end
        decade_cnt u_cnt (
            .clk_i       (CLK_50),
            .rst_ni      (nRST),
            .sync_clr_i  (sync_clr),
            .carry_i     (carry_in),
            .count_next_o(dec_next[j]),
            .carry_o     (carry_out)
        );
        assign tick_raw[j+1] = carry_out;
    end

    // Outputs are registered from next-state values so rising edges land with the tick.
    always_comb begin
        tick_d   = sync_clr ? '0 : tick_raw;
        raw_d    = '0;
        raw_d[0] = (pre_d < DIV_W'(HALF));
        for (int k = 1; k < N_DECADES; k++) begin
            raw_d[k] = (dec_next[k-1] < DECADE_W'(DECADE_HALF));
        end
        en_d = en_q;
        for (int k = 0; k < N_DECADES; k++) begin
            if (tick_d[k]) en_d[k] = en[k];
        end
        if (sync_clr) en_d = '0;
        clk_out_d = sync_clr ? '0 : (raw_d & en_d);
    end

    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            pre_q     <= '0;
            tick_q    <= '0;
            en_q      <= '0;
            clk_out_q <= '0;
        end else begin
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            en_q      <= en_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_out_q;

    gate_state_e      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sel_tick;

    always_comb begin
        sel_tick = 1'b0;
        for (int k = 0; k < N_DECADES; k++) begin
            if (sel_q == SEL_W'(k)) sel_tick = tick_q[k];
        end
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            StIdle: begin
                if (!sync_clr && gate_start) begin
                    sel_d   = (gate_sel > SEL_MAX) ? SEL_MAX : gate_sel;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (sync_clr)      state_d = StIdle;
                else if (sel_tick) state_d = StOpen;
            end
            StOpen: begin
                if (sync_clr)      state_d = StIdle;
                else if (sel_tick) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    assign gate      = (state_q == StOpen);
    assign gate_busy = (state_q == StArm) || (state_q == StOpen);
    assign gate_done = (state_q == StDone);

endmodule

// File: tb/tb_decade_timebase.sv
// Directed bench for decade_timebase with R=4, three decades.
module tb_decade_timebase;

    localparam int unsigned CLK_FREQ  = 20;
    localparam int unsigned BASE_FREQ = 5;
    localparam int unsigned N_DEC     = 3;
    localparam int unsigned SEL_W     = 3;

    logic             CLK_50 = 1'b0;
    logic             nRST = 1'b1;
    logic             sync_clr = 1'b0;
    logic             gate_start = 1'b0;
    logic [N_DEC-1:0] en = 3'b111;
    logic [SEL_W-1:0] gate_sel = '0;
    logic [N_DEC-1:0] clk_out;
    logic [N_DEC-1:0] tick;
    logic             gate, gate_busy, gate_done;

    int unsigned edges;
    int          n_checks = 0;
    int          n_fail = 0;
    int          coincide_err = 0;

    typedef struct {
        int unsigned n;
        logic [2:0]  exp_tick;
        logic [2:0]  exp_clk;
    } sched_t;

    sched_t sched [19];

    decade_timebase #(
        .CLK_FREQ (CLK_FREQ),
        .BASE_FREQ(BASE_FREQ),
        .N_DECADES(N_DEC),
        .SEL_W    (SEL_W)
    ) dut (
        .CLK_50    (CLK_50),
        .nRST      (nRST),
        .sync_clr  (sync_clr),
        .en        (en),
        .clk_out   (clk_out),
        .tick      (tick),
        .gate_sel  (gate_sel),
        .gate_start(gate_start),
        .gate      (gate),
        .gate_busy (gate_busy),
        .gate_done (gate_done)
    );

    always #5 CLK_50 = ~CLK_50;

    // Edges since reset release; sampled values at the following negedge belong to edge n.
    always @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) edges <= 0;
        else       edges <= edges + 1;
    end

    always @(negedge CLK_50) begin
        if (nRST && tick[2] && (tick[1:0] != 2'b11)) coincide_err++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edges);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK_50);
        nRST       = 1'b0;
        sync_clr   = 1'b0;
        gate_start = 1'b0;
        en         = 3'b111;
        gate_sel   = '0;
        repeat (2) @(negedge CLK_50);
        nRST = 1'b1;
    endtask

    task automatic wait_edge(input int unsigned n);
        int guard = 0;
        while (edges != n && guard < 2000) begin
            @(negedge CLK_50);
            guard++;
        end
        if (edges != n) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_edge: got edge %0d expected %0d", edges, n);
        end
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 19; i++) begin
            wait_edge(sched[i].n);
            check($sformatf("%s_tick@%0d", tag, sched[i].n), 32'(tick), 32'(sched[i].exp_tick));
            check($sformatf("%s_clk@%0d", tag, sched[i].n), 32'(clk_out), 32'(sched[i].exp_clk));
        end
    endtask

    task automatic observe(input int unsigned from_n, input int unsigned to_n,
                           input int unsigned poke_n,
                           output int gate_cnt, output int first_n, output int last_n,
                           output int done_cnt, output int done_n, output int busy_cnt);
        gate_cnt = 0; first_n = -1; last_n = -1;
        done_cnt = 0; done_n = -1; busy_cnt = 0;
        for (int unsigned i = from_n; i <= to_n; i++) begin
            wait_edge(i);
            if (gate) begin
                gate_cnt++;
                if (first_n < 0) first_n = int'(i);
                last_n = int'(i);
            end
            if (gate_done) begin
                done_cnt++;
                done_n = int'(i);
            end
            if (gate_busy) busy_cnt++;
            gate_start = (poke_n != 0) && (i == poke_n);
        end
        gate_start = 1'b0;
    endtask

    initial begin
        int gc, fn, ln, dc, dn, bc, cnt;

        sched[0]  = '{0,   3'b000, 3'b000};
        sched[1]  = '{1,   3'b000, 3'b000};
        sched[2]  = '{3,   3'b000, 3'b000};
        sched[3]  = '{4,   3'b001, 3'b001};
        sched[4]  = '{5,   3'b000, 3'b001};
        sched[5]  = '{6,   3'b000, 3'b000};
        sched[6]  = '{8,   3'b001, 3'b001};
        sched[7]  = '{39,  3'b000, 3'b000};
        sched[8]  = '{40,  3'b011, 3'b011};
        sched[9]  = '{41,  3'b000, 3'b011};
        sched[10] = '{59,  3'b000, 3'b010};
        sched[11] = '{60,  3'b001, 3'b001};
        sched[12] = '{80,  3'b011, 3'b011};
        sched[13] = '{399, 3'b000, 3'b000};
        sched[14] = '{400, 3'b111, 3'b111};
        sched[15] = '{401, 3'b000, 3'b111};
        sched[16] = '{600, 3'b011, 3'b011};
        sched[17] = '{799, 3'b000, 3'b000};
        sched[18] = '{800, 3'b111, 3'b111};

        // Free-running schedule after reset
        do_reset();
        check("reset_gate", 32'({gate, gate_busy, gate_done}), 32'd0);
        run_table("sched");
        cnt = 0;
        for (int unsigned i = 801; i <= 840; i++) begin
            wait_edge(i);
            if (clk_out[0]) cnt++;
        end
        check("clk0_duty", 32'(cnt), 32'd20);
        check("tick2_coincide", 32'(coincide_err), 32'd0);

        // Enable drop and re-enable on decade 1
        do_reset();
        wait_edge(50);
        en = 3'b101;
        wait_edge(59);
        check("en_hold_high", 32'(clk_out), 32'b010);
        wait_edge(60);
        check("en_fall", 32'(clk_out), 32'b001);
        wait_edge(81);
        check("en_off", 32'(clk_out), 32'b001);
        wait_edge(95);
        en = 3'b111;
        wait_edge(120);
        check("en_on_clk", 32'(clk_out), 32'b011);
        check("en_on_tick", 32'(tick), 32'b011);

        // Gate window on decade 1
        do_reset();
        wait_edge(45);
        gate_sel   = 3'd1;
        gate_start = 1'b1;
        wait_edge(46);
        gate_start = 1'b0;
        gate_sel   = 3'd0;
        check("g1_busy_arm", 32'({gate, gate_busy}), 32'b01);
        observe(46, 130, 0, gc, fn, ln, dc, dn, bc);
        check("g1_len", 32'(gc), 32'd40);
        check("g1_first", 32'(fn), 32'd81);
        check("g1_last", 32'(ln), 32'd120);
        check("g1_done_cnt", 32'(dc), 32'd1);
        check("g1_done_at", 32'(dn), 32'd121);
        check("g1_busy_len", 32'(bc), 32'd75);

        // Clamped select and ignored restart during OPEN
        do_reset();
        wait_edge(5);
        gate_sel   = 3'd7;
        gate_start = 1'b1;
        wait_edge(6);
        gate_start = 1'b0;
        gate_sel   = 3'd0;
        observe(6, 850, 500, gc, fn, ln, dc, dn, bc);
        check("g7_len", 32'(gc), 32'd400);
        check("g7_first", 32'(fn), 32'd401);
        check("g7_done_cnt", 32'(dc), 32'd1);
        check("g7_done_at", 32'(dn), 32'd801);
        check("g7_busy_len", 32'(bc), 32'd795);

        // sync_clr aborts an open window and realigns
        do_reset();
        wait_edge(1);
        gate_sel   = 3'd1;
        gate_start = 1'b1;
        wait_edge(2);
        gate_start = 1'b0;
        wait_edge(50);
        check("clr_pre_open", 32'(gate), 32'd1);
        sync_clr = 1'b1;
        wait_edge(51);
        sync_clr = 1'b0;
        check("clr_gate", 32'({gate, gate_busy, gate_done}), 32'd0);
        check("clr_outputs", 32'({clk_out, tick}), 32'd0);
        cnt = 0;
        for (int unsigned i = 52; i <= 54; i++) begin
            wait_edge(i);
            if (tick != 0 || gate_done || gate_busy) cnt++;
        end
        check("clr_quiet", 32'(cnt), 32'd0);
        wait_edge(55);
        check("clr_first_tick", 32'(tick), 32'b001);
        sync_clr   = 1'b1;
        gate_start = 1'b1;
        wait_edge(56);
        sync_clr   = 1'b0;
        gate_start = 1'b0;
        check("clr_wins_busy", 32'(gate_busy), 32'd0);
        wait_edge(60);
        check("clr_wins_tick", 32'(tick), 32'b001);
        check("clr_wins_idle", 32'({gate_busy, gate_done}), 32'd0);

        // Asynchronous reset during ARM
        do_reset();
        wait_edge(3);
        gate_sel   = 3'd2;
        gate_start = 1'b1;
        wait_edge(4);
        gate_start = 1'b0;
        wait_edge(9);
        check("rst_pre_state", 32'({clk_out, gate_busy}), 32'b0011);
        nRST = 1'b0;
        #1;
        check("rst_async", 32'({clk_out, tick, gate, gate_busy, gate_done}), 32'd0);
        repeat (2) @(negedge CLK_50);
        nRST = 1'b1;
        run_table("resched");
        check("rst_gate_idle", 32'({gate, gate_busy, gate_done}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
